// File: rtl/fp_normalizer.sv
// Post-add normalization stage of the FP adder: renormalizes the raw mantissa sum
// one bit per cycle, packs {sign, exp, frac} with truncation and holds it under valid/ready.
module fp_normalizer #(
    parameter int unsigned FRAC_W = 23,
    parameter int unsigned EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [FRAC_W+1:0]         in_mant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_result,
    output logic                      out_zero,
    output logic                      out_ovf,
    output logic                      out_unf
);

    localparam int unsigned MANT_W = FRAC_W + 2;
    localparam int unsigned XW     = EXP_W + 1;
    localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;

    localparam logic [XW-1:0] EXP_MAX = XW'({EXP_W{1'b1}});
    localparam logic [XW-1:0] EXP_ONE = XW'(1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SHIFT_R,
        SHIFT_L,
        PACK,
        DONE
    } state_t;

    state_t              state;
    logic                sign_q;
    logic [XW-1:0]       exp_q;
    logic [MANT_W-1:0]   mant_q;

    // Signed zero or signed infinity: fraction is always cleared.
    function automatic logic [RES_W-1:0] special(input logic s, input logic inf);
        special = {s, (inf ? {EXP_W{1'b1}} : {EXP_W{1'b0}}), {FRAC_W{1'b0}}};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        exp_q  <= {1'b0, in_exp};
                        mant_q <= in_mant;
                        state  <= CHECK;
                    end
                end

                CHECK: begin
                    if (mant_q == '0) begin
                        out_result <= special(sign_q, 1'b0);
                        out_zero   <= 1'b1;
                        out_ovf    <= 1'b0;
                        out_unf    <= 1'b0;
                        state      <= DONE;
                    end else if (exp_q == EXP_MAX) begin
                        out_result <= special(sign_q, 1'b1);
                        out_zero   <= 1'b0;
                        out_ovf    <= 1'b1;
                        out_unf    <= 1'b0;
                        state      <= DONE;
                    end else if (exp_q == '0) begin
                        out_result <= special(sign_q, 1'b0);
                        out_zero   <= 1'b0;
                        out_ovf    <= 1'b0;
                        out_unf    <= 1'b1;
                        state      <= DONE;
                    end else if (mant_q[FRAC_W+1]) begin
                        state <= SHIFT_R;
                    end else if (mant_q[FRAC_W]) begin
                        state <= PACK;
                    end else begin
                        state <= SHIFT_L;
                    end
                end

                // Carry-out: single right shift; the widened exponent cannot wrap.
                SHIFT_R: begin
                    mant_q <= mant_q >> 1;
                    exp_q  <= exp_q + XW'(1);
                    if ((exp_q + XW'(1)) == EXP_MAX) begin
                        out_result <= special(sign_q, 1'b1);
                        out_zero   <= 1'b0;
                        out_ovf    <= 1'b1;
                        out_unf    <= 1'b0;
                        state      <= DONE;
                    end else begin
                        state <= PACK;
                    end
                end

                SHIFT_L: begin
                    if (mant_q[FRAC_W]) begin
                        state <= PACK;
                    end else if (exp_q == EXP_ONE) begin
                        out_result <= special(sign_q, 1'b0);
                        out_zero   <= 1'b0;
                        out_ovf    <= 1'b0;
                        out_unf    <= 1'b1;
                        state      <= DONE;
                    end else begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - XW'(1);
                    end
                end

                PACK: begin
                    out_result <= {sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W-1:0]};
                    out_zero   <= 1'b0;
                    out_ovf    <= 1'b0;
                    out_unf    <= 1'b0;
                    state      <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed-vector bench for fp_normalizer: checks packed result, flags, latency,
// output hold under backpressure and mid-operation reset.
module tb_fp_normalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    int nvec;
    int nerr;

    fp_normalizer #(.FRAC_W(23), .EXP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operand, measure latency, check result and flags, then optionally
    // hold out_ready low before completing the handshake.
    task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                           input logic [24:0] m, input logic [31:0] res,
                           input logic z, input logic o, input logic u,
                           input int lat_exp, input int hold);
        int lat;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sign  = 1'($urandom);
        in_exp   = 8'($urandom);
        in_mant  = 25'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 200);
        check({tag, ".latency"}, 64'(lat), 64'(lat_exp));
        check({tag, ".result"}, 64'(out_result), 64'(res));
        check({tag, ".flags"}, 64'({out_zero, out_ovf, out_unf}), 64'({z, o, u}));
        check({tag, ".busy"}, 64'(in_ready), 64'(0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
            check({tag, ".hold_result"}, 64'(out_result), 64'(res));
            check({tag, ".hold_ready"}, 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".released"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        int seen;
        nvec      = 0;
        nerr      = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.in_ready", 64'(in_ready), 64'(1));
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.result", 64'(out_result), 64'(0));
        check("reset.flags", 64'({out_zero, out_ovf, out_unf}), 64'(0));

        //      tag           s     exp    mant          result        z     o     u    L  hold
        run_vec("normal",    1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 2, 0);
        run_vec("carry",     1'b0, 8'h7F, 25'h1800001, 32'h40400000, 1'b0, 1'b0, 1'b0, 3, 0);
        run_vec("carry_ovf", 1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1'b0, 1'b1, 1'b0, 2, 0);
        run_vec("carry_max", 1'b0, 8'hFD, 25'h1000000, 32'h7F000000, 1'b0, 1'b0, 1'b0, 3, 0);
        run_vec("left23",    1'b1, 8'h7F, 25'h0000001, 32'hB4000000, 1'b0, 1'b0, 1'b0, 26, 0);
        run_vec("left1",     1'b0, 8'h80, 25'h0400003, 32'h3F800006, 1'b0, 1'b0, 1'b0, 4, 0);
        run_vec("unf4",      1'b0, 8'h05, 25'h0000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 6, 0);
        run_vec("unf0",      1'b1, 8'h01, 25'h0000010, 32'h80000000, 1'b0, 1'b0, 1'b1, 2, 0);
        run_vec("zero",      1'b1, 8'h7F, 25'h0000000, 32'h80000000, 1'b1, 0, 0, 1, 0);
        run_vec("inf_in",    1'b0, 8'hFF, 25'h0812345, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1, 0);
        run_vec("exp0_in",   1'b1, 8'h00, 25'h0812345, 32'h80000000, 1'b0, 1'b0, 1'b1, 1, 0);
        run_vec("hold5",     1'b1, 8'h81, 25'h0C00000, 32'hC0C00000, 1'b0, 1'b0, 1'b0, 2, 5);

        // Reset while left-shifting: operand dropped, no result emitted.
        in_valid = 1'b1;
        in_sign  = 1'b1;
        in_exp   = 8'h7F;
        in_mant  = 25'h0000001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst.in_ready", 64'(in_ready), 64'(1));
        check("midrst.out_valid", 64'(out_valid), 64'(0));
        check("midrst.result", 64'(out_result), 64'(0));
        check("midrst.flags", 64'({out_zero, out_ovf, out_unf}), 64'(0));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst.no_emit", 64'(seen), 64'(0));

        run_vec("post_rst",  1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fp_normalizer.md
# fp_normalizer

Post-add normalization stage of the FP_Add datapath. It accepts the raw mantissa sum produced after exponent alignment and mantissa add/subtract, together with the larger exponent and the result sign. It renormalizes the mantissa iteratively: one right shift on carry-out, or one left shift per cycle until the hidden bit is set. It then packs an IEEE-754-style word with truncation and no rounding, and holds it under a valid/ready handshake for the consumer.

## Interface
- FRAC_W, default 23: stored fraction width; the hidden bit is at index FRAC_W.
- EXP_W, default 8: exponent width; all-ones is reserved for infinity.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  high only in IDLE; an operand is accepted on an edge with in_valid & in_ready.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  biased exponent, the max of the aligned operands.
- in_mant  in  FRAC_W+2  unnormalized sum; bit FRAC_W+1 is the carry-out, bit FRAC_W is the hidden position.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer ready.
- out_result  out  1+EXP_W+FRAC_W  packed {sign, exp, frac}.
- out_zero, out_ovf, out_unf  out  1 each  status flags, registered with out_result.

## Operation
- States:
  - IDLE: in_ready=1. On accept, latch sign, exp and mant, then go to CHECK.
  - CHECK:
    - mant==0: result {sign,0,0}, out_zero=1, go to DONE.
    - exp==all-ones: result {sign,all-ones,0}, out_ovf=1, go to DONE.
    - exp==0 (mant nonzero): result {sign,0,0}, out_unf=1, go to DONE.
    - mant[FRAC_W+1]=1: go to SHIFT_R.
    - mant[FRAC_W]=1: go to PACK.
    - otherwise: go to SHIFT_L.
  - SHIFT_R: mant>>=1 with the LSB discarded, exp+=1. If the new exp is all-ones, result is {sign,all-ones,0}, out_ovf=1, go to DONE. Otherwise go to PACK.
  - SHIFT_L, evaluated on registered values each cycle:
    - mant[FRAC_W]=1: go to PACK.
    - exp==1: flush to {sign,0,0}, out_unf=1, go to DONE.
    - otherwise: mant<<=1, exp-=1, stay in SHIFT_L.
  - PACK: out_result={sign, exp, mant[FRAC_W-1:0]}, flags 0, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Exponent arithmetic is EXP_W+1 bits internally, so the increment cannot wrap silently.
- Truncation only; discarded bits have no effect.
- At most one flag is set per result.
- out_result and the flags are registered and stable from DONE entry until the handshake completes.
- Back-to-back operation: a new operand can be accepted on the cycle after the DONE handshake, which is the IDLE cycle.

## Timing
- Latency L is counted from the accept edge n to the first edge at which out_valid is sampled high, n+L:
  - zero / special / exp==0 input: L=1.
  - already normalized: L=2.
  - carry right shift: L=3, or L=2 when the shift overflows.
  - left normalization by k≥1 bits: L=3+k, maximum FRAC_W+3.
  - underflow during left shift after j shifts: L=2+j.
- in_ready and out_valid are decoded from registered state; there is no combinational in-to-out path.
- Reset (any state, including mid-shift):
  - next cycle state is IDLE, in_ready=1, out_valid=0, out_result=0, all flags 0.
  - The in-flight operand is discarded and no result is emitted.
- out_ready is ignored outside DONE.
- in_valid is ignored outside IDLE. Input values need only be stable on the accept edge.

## Test plan
- in_mant=0x800000, in_exp=0x7F, sign 0 -> out_result=0x3F800000, flags 0, L=2.
- Carry: in_mant=0x1800001, in_exp=0x7F -> 0x40400000 (LSB truncated), L=3.
- Carry overflow: in_mant=0x1000000, in_exp=0xFE -> 0x7F800000, out_ovf=1.
- Left normalize: in_mant=0x000001, in_exp=0x7F, sign 1 -> 0xB4000000 (exp 0x68), L=26.
- Underflow: in_mant=0x000001, in_exp=0x05 -> 0x00000000, out_unf=1 after 4 shifts (L=6).
- Zero input with sign 1 -> 0x80000000, out_zero=1, L=1.
- Hold out_ready low for 5 cycles: out_result stable and in_ready=0 throughout.
- Assert rst during SHIFT_L: the next cycle shows IDLE outputs and no result is emitted.
